// File: rtl/ising_prog_master.sv
// ising_prog_master: hardware sequencer that programs an ising_axi instance and reads back spin phases.
// Define ISING_PROG_TIMEOUT_EN to add a per-beat read timeout that sets the sticky err flag.
module ising_prog_master #(
  parameter int          N                = 8,
  parameter int          NUM_WEIGHTS      = 3,
  parameter int          FIFO_DEPTH       = 16,
  parameter int          TIMEOUT          = 255,
  parameter logic [31:0] START_ADDR       = 32'h0000_0000,
  parameter logic [31:0] CTR_CUTOFF_ADDR  = 32'h0000_0008,
  parameter logic [31:0] CTR_MAX_ADDR     = 32'h0000_000C,
  parameter logic [31:0] PHASE_ADDR_BASE  = 32'h0000_1000,
  parameter logic [31:0] WEIGHT_ADDR_BASE = 32'h0100_0000
) (
  input  logic                   clk,
  input  logic                   axi_rst,
  input  logic                   wt_push,
  input  logic [7:0]             wt_i,
  input  logic [7:0]             wt_j,
  input  logic [NUM_WEIGHTS-1:0] wt_val,
  output logic                   wt_full,
  input  logic                   go,
  input  logic [31:0]            cutoff,
  input  logic [31:0]            ctr_max,
  input  logic [31:0]            run_cycles,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [N-1:0]           phases,
  output logic [31:0]            wr_addr,
  output logic [31:0]            wdata,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [31:0]            araddr,
  output logic                   arvalid,
  input  logic [31:0]            rdata,
  input  logic                   rvalid,
  output logic                   rready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = 16 + NUM_WEIGHTS;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LAST_SPIN  = SW'(N - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    W_CUT   = 4'd1,
    W_MAX   = 4'd2,
    W_WT    = 4'd3,
    W_START = 4'd4,
    RUN     = 4'd5,
    RD_ADDR = 4'd6,
    RD_DATA = 4'd7,
    DONE    = 4'd8
  } state_t;

  state_t state, state_next;

  logic [EW-1:0]          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]          count, count_next;
  logic                   push_ok, pop;
  logic [EW-1:0]          head;
  logic [7:0]             head_i, head_j;
  logic [NUM_WEIGHTS-1:0] head_val;

  logic [31:0]   cut_q, max_q, run_q, run_cnt;
  logic [SW-1:0] spin;
  logic          beat_ok, beat_to;
  logic          unused_rdata;

  assign head     = fifo_mem[rd_ptr];
  assign head_i   = head[EW-1 -: 8];
  assign head_j   = head[EW-9 -: 8];
  assign head_val = head[NUM_WEIGHTS-1:0];

  // A full FIFO still accepts a push when the head is leaving on the same edge.
  assign pop     = (state == W_WT) && wready;
  assign push_ok = wt_push && ((count != FULL_COUNT) || pop);

  always_comb begin
    count_next = count;
    if (push_ok && !pop) begin
      count_next = count + CW'(1);
    end else if (!push_ok && pop) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= {wt_i, wt_j, wt_val};
    end
  end

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      wt_full <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count   <= count_next;
      wt_full <= (count_next == FULL_COUNT);
    end
  end

  assign beat_ok      = (state == RD_DATA) && rvalid;
  assign unused_rdata = ^rdata[31:1];

`ifdef ISING_PROG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] to_cnt;
  logic          err_q;

  // The beat gives up once TIMEOUT cycles have passed in RD_DATA without rvalid.
  assign beat_to = (state == RD_DATA) && !rvalid && (to_cnt == TO_LAST);
  assign err     = err_q;

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state == IDLE) && go) begin
        err_q <= 1'b0;
      end else if (beat_to) begin
        err_q <= 1'b1;
      end
      if ((state != RD_DATA) || rvalid || beat_to) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end
`else
  logic unused_timeout;

  assign beat_to        = 1'b0;
  assign err            = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bus outputs are decoded from the state so a stalled write keeps address and data steady.
  always_comb begin
    state_next = state;
    wvalid     = 1'b0;
    wr_addr    = '0;
    wdata      = '0;
    arvalid    = 1'b0;
    araddr     = '0;
    rready     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_next = W_CUT;
        end
      end
      W_CUT: begin
        wvalid  = 1'b1;
        wr_addr = CTR_CUTOFF_ADDR;
        wdata   = cut_q;
        if (wready) begin
          state_next = W_MAX;
        end
      end
      W_MAX: begin
        wvalid  = 1'b1;
        wr_addr = CTR_MAX_ADDR;
        wdata   = max_q;
        if (wready) begin
          state_next = (count_next == '0) ? W_START : W_WT;
        end
      end
      W_WT: begin
        wvalid  = 1'b1;
        wr_addr = WEIGHT_ADDR_BASE + {24'd0, head_i} + {8'd0, head_j, 16'd0};
        wdata   = {{(32 - NUM_WEIGHTS){1'b0}}, head_val};
        if (wready && (count_next == '0)) begin
          state_next = W_START;
        end
      end
      W_START: begin
        wvalid  = 1'b1;
        wr_addr = START_ADDR;
        wdata   = 32'd1;
        if (wready) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (run_cnt == 32'd0) begin
          state_next = RD_ADDR;
        end
      end
      RD_ADDR: begin
        arvalid    = 1'b1;
        rready     = 1'b1;
        araddr     = PHASE_ADDR_BASE + ((32'(N - 1) - 32'(spin)) << 2);
        state_next = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (beat_ok || beat_to) begin
          state_next = (spin == LAST_SPIN) ? DONE : RD_ADDR;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // Job parameters, run countdown and the phase-capture shift through spins.
  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      cut_q   <= '0;
      max_q   <= '0;
      run_q   <= '0;
      run_cnt <= '0;
      spin    <= '0;
      phases  <= '0;
    end else begin
      if ((state == IDLE) && go) begin
        cut_q <= cutoff;
        max_q <= ctr_max;
        run_q <= run_cycles;
        spin  <= '0;
      end
      if ((state == W_START) && wready) begin
        run_cnt <= run_q;
      end else if ((state == RUN) && (run_cnt != 32'd0)) begin
        run_cnt <= run_cnt - 32'd1;
      end
      if (beat_ok || beat_to) begin
        phases[spin] <= rvalid & rdata[0];
        spin         <= spin + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ising_prog_master.sv
// Directed self-checking bench for ising_prog_master with a small ising_axi bus responder model.
`timescale 1ns/1ps
module tb_ising_prog_master;

  localparam int N     = 8;
  localparam int NW    = 3;
  localparam int DEPTH = 16;
  localparam int TMO   = 8;
  localparam logic [31:0] A_START = 32'h0000_0000;
  localparam logic [31:0] A_CUT   = 32'h0000_0008;
  localparam logic [31:0] A_MAX   = 32'h0000_000C;
  localparam logic [31:0] A_PHASE = 32'h0000_1000;
  localparam logic [31:0] A_WT    = 32'h0100_0000;

  logic          clk = 1'b0;
  logic          axi_rst = 1'b1;
  logic          wt_push = 1'b0;
  logic [7:0]    wt_i = '0;
  logic [7:0]    wt_j = '0;
  logic [NW-1:0] wt_val = '0;
  logic          wt_full;
  logic          go = 1'b0;
  logic [31:0]   cutoff = '0;
  logic [31:0]   ctr_max = '0;
  logic [31:0]   run_cycles = '0;
  logic          busy, done, err;
  logic [N-1:0]  phases;
  logic [31:0]   wr_addr, wdata, araddr;
  logic          wvalid, arvalid, rready;
  logic          wready = 1'b1;
  logic [31:0]   rdata = '0;
  logic          rvalid = 1'b0;

  ising_prog_master #(
    .N(N), .NUM_WEIGHTS(NW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO),
    .START_ADDR(A_START), .CTR_CUTOFF_ADDR(A_CUT), .CTR_MAX_ADDR(A_MAX),
    .PHASE_ADDR_BASE(A_PHASE), .WEIGHT_ADDR_BASE(A_WT)
  ) dut (
    .clk(clk), .axi_rst(axi_rst),
    .wt_push(wt_push), .wt_i(wt_i), .wt_j(wt_j), .wt_val(wt_val), .wt_full(wt_full),
    .go(go), .cutoff(cutoff), .ctr_max(ctr_max), .run_cycles(run_cycles),
    .busy(busy), .done(done), .err(err), .phases(phases),
    .wr_addr(wr_addr), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .araddr(araddr), .arvalid(arvalid), .rdata(rdata), .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int go_edge = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_edge[$];
  logic [31:0] ar_log[$];
  int          ar_first_edge = 0;
  int          done_cnt = 0;
  int          done_edge = 0;

  logic [N-1:0] spin_bits = '0;
  int           suppress_off = -1;
  int           stall_idx = -1;
  int           stall_left = 0;
  logic [31:0]  stall_addr = '0;
  logic [31:0]  stall_data = '0;
  logic         pending = 1'b0;
  logic [31:0]  pend_addr = '0;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Responder: ising_axi stand-in driven on the falling edge, one cycle read latency.
  initial forever begin
    int off;
    @(negedge clk);
    if (axi_rst) begin
      pending    = 1'b0;
      rvalid     = 1'b0;
      rdata      = '0;
      wready     = 1'b1;
      stall_left = 0;
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
      if (pending) begin
        pending = 1'b0;
        off = int'((pend_addr - A_PHASE) >> 2);
        if (off != suppress_off) begin
          rvalid = 1'b1;
          rdata  = {16'hBEEF, 15'h0, spin_bits[N-1-off]};
        end
      end
      if (arvalid) begin
        checkOutput("rready_in_rd", rready, 1'b1);
        pending   = 1'b1;
        pend_addr = araddr;
        if (ar_log.size() == 0) ar_first_edge = cyc + 1;
        ar_log.push_back(araddr);
      end
      if (stall_left > 0) begin
        checkOutput("stall_wvalid", wvalid, 1'b1);
        checkOutput("stall_addr_stable", wr_addr, stall_addr);
        checkOutput("stall_data_stable", wdata, stall_data);
        stall_left--;
        wready = (stall_left == 0);
        if (stall_left == 0) begin
          log_addr.push_back(wr_addr);
          log_data.push_back(wdata);
          log_edge.push_back(cyc + 1);
        end
      end else if (wvalid) begin
        if (log_addr.size() == stall_idx) begin
          stall_idx  = -1;
          stall_addr = wr_addr;
          stall_data = wdata;
          stall_left = 5;
          wready     = 1'b0;
        end else begin
          wready = 1'b1;
          log_addr.push_back(wr_addr);
          log_data.push_back(wdata);
          log_edge.push_back(cyc + 1);
        end
      end else begin
        wready = 1'b1;
      end
      if (done) begin
        done_cnt++;
        done_edge = cyc;
      end
    end
  end

  task automatic pushWeight(input int i, input int j, input int v);
    wt_push = 1'b1;
    wt_i    = 8'(i);
    wt_j    = 8'(j);
    wt_val  = NW'(v);
    @(negedge clk);
    wt_push = 1'b0;
  endtask

  task automatic clearLog();
    log_addr.delete();
    log_data.delete();
    log_edge.delete();
    ar_log.delete();
    done_cnt = 0;
  endtask

  task automatic applyStimulus(input logic [31:0] c, input logic [31:0] m, input logic [31:0] r);
    cutoff     = c;
    ctr_max    = m;
    run_cycles = r;
    go         = 1'b1;
    go_edge    = cyc + 1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done_seen"}, (done_cnt != 0), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkWrite(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] oa = 'x;
    logic [31:0] od = 'x;
    if (idx < log_addr.size()) begin
      oa = log_addr[idx];
      od = log_data[idx];
    end
    checkOutput({tag, "_addr"}, oa, a);
    checkOutput({tag, "_data"}, od, d);
  endtask

  initial begin
    int wi[10] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 3};
    int wj[10] = '{1, 4, 7, 2, 3, 7, 3, 7, 4, 7};
    int wv[10] = '{1, 1, 4, 1, 1, 4, 1, 4, 1, 4};
    int t_start;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_phases", phases, 8'h00);
    checkOutput("rst_wt_full", wt_full, 1'b0);
    checkOutput("rst_wvalid", wvalid, 1'b0);
    checkOutput("rst_arvalid", arvalid, 1'b0);
    checkOutput("rst_rready", rready, 1'b0);
    checkOutput("rst_wr_addr", wr_addr, 32'h0);
    checkOutput("rst_wdata", wdata, 32'h0);
    checkOutput("rst_araddr", araddr, 32'h0);
    axi_rst = 1'b0;
    @(negedge clk);

    // Job 1: max-cut programming with free-running bus
    $display("[TB] job1: max-cut graph, 10 weights, run 500");
    for (int k = 0; k < 10; k++) pushWeight(wi[k], wj[k], wv[k]);
    checkOutput("j1_not_full", wt_full, 1'b0);
    spin_bits = 8'hCD;
    clearLog();
    applyStimulus(32'h4000, 32'h8000, 32'd500);
    checkOutput("j1_busy_after_go", busy, 1'b1);
    checkOutput("j1_wvalid_after_go", wvalid, 1'b1);
    checkOutput("j1_first_addr", wr_addr, A_CUT);
    waitDone("j1", 1000);
    checkOutput("j1_write_count", log_addr.size(), 13);
    checkWrite("j1_cut", 0, A_CUT, 32'h4000);
    checkWrite("j1_max", 1, A_MAX, 32'h8000);
    for (int k = 0; k < 10; k++)
      checkWrite($sformatf("j1_w%0d", k), k + 2, A_WT + 32'(wi[k]) + (32'(wj[k]) << 16), 32'(wv[k]));
    checkWrite("j1_start", 12, A_START, 32'd1);
    checkOutput("j1_cut_edge", (log_edge.size() > 0) ? log_edge[0] : -1, go_edge + 1);
    t_start = (log_edge.size() > 12) ? log_edge[12] : -1;
    checkOutput("j1_start_edge", t_start, go_edge + 13);
    checkOutput("j1_first_read_edge", ar_first_edge, t_start + 502);
    checkOutput("j1_done_edge", done_edge, ar_first_edge + 15);
    checkOutput("j1_read_count", ar_log.size(), 8);
    checkOutput("j1_read0_addr", (ar_log.size() > 0) ? ar_log[0] : 'x, A_PHASE + 32'd28);
    checkOutput("j1_read7_addr", (ar_log.size() > 7) ? ar_log[7] : 'x, A_PHASE);
    checkOutput("j1_done_once", done_cnt, 1);
    checkOutput("j1_busy_end", busy, 1'b0);
    checkOutput("j1_spin_A", phases[0], 1'b1);
    checkOutput("j1_spin_B", phases[1], 1'b0);
    checkOutput("j1_spin_C", phases[2], 1'b1);
    checkOutput("j1_spin_D", phases[3], 1'b1);
    checkOutput("j1_spin_E", phases[4], 1'b0);
    checkOutput("j1_spin_F", phases[5], 1'b0);
    checkOutput("j1_spin_G", phases[6], 1'b1);
    checkOutput("j1_spin_H", phases[7], 1'b1);

    // Job 2: second weight write stalled for five cycles, zero-cycle run
    $display("[TB] job2: wready stall on second weight write");
    pushWeight(5, 6, 2);
    pushWeight(7, 8, 3);
    pushWeight(9, 10, 5);
    spin_bits = 8'h3A;
    clearLog();
    stall_idx = 3;
    applyStimulus(32'h11, 32'h22, 32'd0);
    waitDone("j2", 200);
    checkOutput("j2_write_count", log_addr.size(), 6);
    checkWrite("j2_cut", 0, A_CUT, 32'h11);
    checkWrite("j2_max", 1, A_MAX, 32'h22);
    checkWrite("j2_w0", 2, 32'h0106_0005, 32'd2);
    checkWrite("j2_w1", 3, 32'h0108_0007, 32'd3);
    checkWrite("j2_w2", 4, 32'h010A_0009, 32'd5);
    checkWrite("j2_start", 5, A_START, 32'd1);
    checkOutput("j2_w1_edge", (log_edge.size() > 3) ? log_edge[3] : -1, go_edge + 9);
    checkOutput("j2_dwell", ar_first_edge, ((log_edge.size() > 5) ? log_edge[5] : -100) + 2);
    checkOutput("j2_phases", phases, 8'h3A);

    // Job 3: 17 pushes into a 16-deep FIFO
    $display("[TB] job3: FIFO overflow drop");
    for (int k = 0; k < 15; k++) pushWeight(k, 20 + k, k % 8);
    checkOutput("j3_full_after_15", wt_full, 1'b0);
    pushWeight(15, 35, 7);
    checkOutput("j3_full_after_16", wt_full, 1'b1);
    pushWeight(16, 36, 0);
    checkOutput("j3_full_after_17", wt_full, 1'b1);
    spin_bits = 8'h96;
    clearLog();
    applyStimulus(32'h1, 32'h2, 32'd3);
    waitDone("j3", 300);
    checkOutput("j3_write_count", log_addr.size(), 19);
    checkWrite("j3_w0", 2, 32'h0114_0000, 32'd0);
    checkWrite("j3_w9", 11, 32'h011D_0009, 32'd1);
    checkWrite("j3_w15", 17, 32'h0123_000F, 32'd7);
    checkWrite("j3_start", 18, A_START, 32'd1);
    checkOutput("j3_full_end", wt_full, 1'b0);
    checkOutput("j3_phases", phases, 8'h96);

`ifdef ISING_PROG_TIMEOUT_EN
    // Timeout job: spin 3 never answers
    $display("[TB] timeout: spin 3 read response suppressed");
    pushWeight(1, 2, 3);
    spin_bits    = 8'hCD;
    suppress_off = N - 1 - 3;
    clearLog();
    applyStimulus(32'h5, 32'h6, 32'd2);
    waitDone("to", 300);
    suppress_off = -1;
    checkOutput("to_err", err, 1'b1);
    checkOutput("to_spin3", phases[3], 1'b0);
    checkOutput("to_phases", phases, 8'hC5);
    checkOutput("to_done_once", done_cnt, 1);
`endif

    // Job 4: go pulse during RUN must be ignored
    $display("[TB] job4: go during RUN");
    pushWeight(2, 3, 6);
    spin_bits = 8'hFF;
    clearLog();
    applyStimulus(32'hA, 32'hB, 32'd40);
    checkOutput("j4_err_cleared", err, 1'b0);
    repeat (10) @(negedge clk);
    applyStimulus(32'h1234, 32'h5678, 32'd0);
    waitDone("j4", 300);
    repeat (30) @(negedge clk);
    checkOutput("j4_done_once", done_cnt, 1);
    checkOutput("j4_write_count", log_addr.size(), 4);
    checkWrite("j4_cut", 0, A_CUT, 32'hA);
    checkWrite("j4_wt", 2, 32'h0103_0002, 32'd6);
    checkWrite("j4_start", 3, A_START, 32'd1);
    checkOutput("j4_busy_end", busy, 1'b0);
    checkOutput("j4_phases", phases, 8'hFF);

    // Reset in the middle of W_WT
    $display("[TB] reset during weight writes");
    for (int k = 0; k < 5; k++) pushWeight(k, k + 1, k);
    clearLog();
    applyStimulus(32'h77, 32'h88, 32'd10);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rw_pre_wvalid", wvalid, 1'b1);
    checkOutput("rw_pre_addr", wr_addr, 32'h0103_0002);
    #1;
    axi_rst = 1'b1;
    #1;
    checkOutput("rw_busy", busy, 1'b0);
    checkOutput("rw_wvalid", wvalid, 1'b0);
    checkOutput("rw_wr_addr", wr_addr, 32'h0);
    checkOutput("rw_wdata", wdata, 32'h0);
    checkOutput("rw_phases", phases, 8'h00);
    checkOutput("rw_wt_full", wt_full, 1'b0);
    checkOutput("rw_done", done, 1'b0);
    checkOutput("rw_err", err, 1'b0);
    checkOutput("rw_arvalid", arvalid, 1'b0);
    checkOutput("rw_rready", rready, 1'b0);
    checkOutput("rw_araddr", araddr, 32'h0);
    repeat (2) @(negedge clk);
    axi_rst = 1'b0;
    @(negedge clk);

    // Job 5: clean job from an emptied FIFO
    $display("[TB] job5: clean job after reset");
    spin_bits = 8'h5C;
    clearLog();
    applyStimulus(32'h99, 32'hAA, 32'd1);
    waitDone("j5", 200);
    checkOutput("j5_write_count", log_addr.size(), 3);
    checkWrite("j5_cut", 0, A_CUT, 32'h99);
    checkWrite("j5_max", 1, A_MAX, 32'hAA);
    checkWrite("j5_start", 2, A_START, 32'd1);
    checkOutput("j5_start_edge", (log_edge.size() > 2) ? log_edge[2] : -1, go_edge + 3);
    checkOutput("j5_phases", phases, 8'h5C);
    checkOutput("j5_err", err, 1'b0);
    checkOutput("j5_done_once", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
